// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU owns the port by default, a host burst engine borrows it
// beat by beat and yields to the CPU every CHUNK beats. Optional macro: DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 8,
  parameter int unsigned LW       = 8,
  parameter int unsigned CHUNK    = 4,
  parameter int unsigned WAIT_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [LW-1:0] host_len,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_beat,
  output logic [DW-1:0] host_rdata,
  output logic          host_done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   cpu_stall_cnt
`endif
);

  localparam int unsigned WCW = $clog2(WAIT_MAX + 1);
  localparam int unsigned CCW = $clog2(CHUNK + 1);
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(WAIT_MAX - 1);
  localparam logic [CCW-1:0] CHUNK_LAST = CCW'(CHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_YIELD
  } state_e;

  state_e          state_q, state_d;
  logic [WCW-1:0]  wait_q, wait_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [LW-1:0]   len_q, len_d;
  logic            we_q, we_d;
  logic [LW-1:0]   beat_q, beat_d;
  logic [CCW-1:0]  chunk_q, chunk_d;
  logic            grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      we_q    <= 1'b0;
      beat_q  <= '0;
      chunk_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      we_q    <= we_d;
      beat_q  <= beat_d;
      chunk_q <= chunk_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    addr_d    = addr_q;
    len_d     = len_q;
    we_d      = we_q;
    beat_d    = beat_q;
    chunk_d   = chunk_q;
    grant     = 1'b0;
    host_gnt  = 1'b0;
    host_beat = 1'b0;
    host_done = 1'b0;
    cpu_stall = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = cpu_req & cpu_we;

    case (state_q)
      S_IDLE: begin
        grant    = host_req & (~cpu_req | (wait_q == WAIT_LAST));
        host_gnt = grant;
        if (grant) begin
          addr_d  = host_addr;
          len_d   = host_len;
          we_d    = host_we;
          beat_d  = '0;
          chunk_d = '0;
          wait_d  = '0;
          state_d = S_BURST;
        end else if (host_req && cpu_req) begin
          wait_d = wait_q + 1'b1;
        end else begin
          wait_d = '0;
        end
      end
      S_BURST: begin
        host_beat = 1'b1;
        cpu_stall = cpu_req;
        mem_addr  = addr_q;
        mem_wdata = host_wdata;
        mem_we    = we_q;
        if (beat_q == len_q) begin
          host_done = 1'b1;
          state_d   = S_IDLE;
        end else begin
          addr_d = addr_q + 1'b1;
          beat_d = beat_q + 1'b1;
          // chunk counter saturates so a CPU request arriving late still forces a yield
          if (chunk_q == CHUNK_LAST) begin
            if (cpu_req) begin
              chunk_d = '0;
              state_d = S_YIELD;
            end
          end else begin
            chunk_d = chunk_q + 1'b1;
          end
        end
      end
      S_YIELD: state_d = S_BURST;
      default: state_d = S_IDLE;
    endcase

    if (!reset) begin
      host_gnt = 1'b0;
      mem_we   = 1'b0;
    end
  end

  assign cpu_rdata  = mem_rdata;
  assign host_rdata = mem_rdata;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (cpu_stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign cpu_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: driver pushes expected beats/CPU accesses computed from
// a schedule model, a negedge monitor pops and compares whenever the DUT presents them.
module tb_dmem_arbiter;
  localparam int CHUNK    = 4;
  localparam int WAIT_MAX = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       cpu_stall;
  logic       host_req, host_we;
  logic [7:0] host_addr, host_len, host_wdata;
  logic       host_gnt, host_beat, host_done;
  logic [7:0] host_rdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] cpu_stall_cnt;
`endif

  dmem_arbiter #(.AW(8), .DW(8), .LW(8), .CHUNK(CHUNK), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_len(host_len),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_beat(host_beat),
    .host_rdata(host_rdata), .host_done(host_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .cpu_stall_cnt(cpu_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // data_mem stand-in: combinational read, synchronous write
  logic [7:0] mem [256];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  logic [7:0] ref_mem [256];

  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic       we;
    logic [7:0] data;
    logic       done;
    logic       stall;
  } beat_t;

  typedef struct {
    logic [7:0] addr;
    logic       we;
    logic [7:0] data;
  } cpu_t;

  beat_t bq[$];
  cpu_t  cq[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  logic  cpu_chk = 1'b0;
  int    gcyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    beat_t b;
    cpu_t  c;
    if (reset) begin
      if (host_gnt) gcyc = 0;
      else gcyc++;
      if (host_beat) begin
        if (bq.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          b = bq.pop_front();
          chk("beat_cycle", gcyc, b.cyc);
          chk("beat_addr", mem_addr, b.addr);
          chk("beat_we", mem_we, b.we);
          chk("beat_done", host_done, b.done);
          chk("beat_stall", cpu_stall, b.stall);
          chk("beat_no_gnt", host_gnt, 0);
          if (b.we) chk("beat_wdata", mem_wdata, b.data);
          else      chk("beat_rdata", host_rdata, b.data);
        end
      end else begin
        chk("stall_cpu_owner", cpu_stall, 0);
        chk("done_without_beat", host_done, 0);
        if (cpu_req) begin
          chk("cpu_owner_addr", mem_addr, cpu_addr);
          chk("cpu_owner_we", mem_we, cpu_we);
          if (cpu_chk) begin
            if (cq.size() == 0) begin
              chk("unexpected_cpu", 1, 0);
            end else begin
              c = cq.pop_front();
              chk("cpu_addr", mem_addr, c.addr);
              if (c.we) chk("cpu_wdata", mem_wdata, c.data);
              else      chk("cpu_rdata", cpu_rdata, c.data);
            end
          end
        end else begin
          chk("we_without_req", mem_we, 0);
        end
      end
    end
  end

  task automatic cpu_phase(input int n, input bit fill);
    cpu_t c;
    cpu_chk = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      host_req  = 1'b0;
      cpu_req   = fill ? 1'b1 : 1'($urandom_range(1));
      cpu_we    = fill ? 1'b1 : 1'($urandom_range(1));
      cpu_addr  = fill ? 8'(i) : 8'($urandom);
      cpu_wdata = 8'($urandom);
      if (cpu_req) begin
        c.addr = cpu_addr;
        c.we   = cpu_we;
        c.data = cpu_we ? cpu_wdata : ref_mem[cpu_addr];
        cq.push_back(c);
        if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
      end
      @(negedge clk);
    end
    #1;
    chk("cpu_queue_drained", cq.size(), 0);
    cq.delete();
    cpu_chk = 1'b0;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  // gmode: 0 CPU idle at request, 1 CPU busy throughout, 2 random.
  // rmode: cpu_req during the burst, same encoding. stop_after>0 aborts with reset.
  task automatic burst(input logic [7:0] a, input logic [7:0] len, input bit we,
                       input int gmode, input int rmode, input bit fixed_wd, input int stop_after);
    bit         gp [WAIT_MAX];
    bit         rq [64];
    logic [7:0] wd [256];
    int         sched [$];
    int         n, k_exp, got, beats, run, idx;
    int         exp_stalls;
    bit         yield_next;
    beat_t      b;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] cnt0 = '0;
`endif
    n = int'(len) + 1;
    for (int i = 0; i < WAIT_MAX; i++)
      gp[i] = (gmode == 0) ? 1'b0 : (gmode == 1) ? 1'b1 : ($urandom_range(3) != 0);
    for (int i = 0; i < 64; i++)
      rq[i] = (rmode == 0) ? 1'b0 : (rmode == 1) ? 1'b1 : 1'($urandom_range(1));
    for (int i = 0; i < n; i++) wd[i] = fixed_wd ? 8'(8'hA0 + i) : 8'($urandom);

    k_exp = WAIT_MAX - 1;
    for (int i = 0; i < WAIT_MAX; i++)
      if (!gp[i]) begin k_exp = i; break; end

    got = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      host_req  = 1'b1;
      host_we   = we;
      host_addr = a;
      host_len  = len;
      cpu_req   = (i < WAIT_MAX) ? gp[i] : 1'b1;
      cpu_we    = 1'b0;
      cpu_addr  = 8'($urandom);
      @(negedge clk);
      if (host_gnt) begin got = i; break; end
    end
    chk("grant_cycle", got, k_exp);
    if (got < 0) begin
      @(posedge clk); #1;
      host_req = 1'b0;
      return;
    end
`ifdef DMEM_ARB_STATS_EN
    cnt0 = cpu_stall_cnt;
`endif

    // schedule: a beat per cycle; a yield cycle follows CHUNK+ unbroken beats whose last saw cpu_req
    beats = 0; run = 0; yield_next = 1'b0; exp_stalls = 0;
    for (int c = 1; beats < n; c++) begin
      if (yield_next) begin
        sched.push_back(-1);
        yield_next = 1'b0;
        run = 0;
      end else begin
        idx    = beats;
        b.cyc  = c;
        b.addr = 8'(a + idx);
        b.we   = we;
        b.done = (idx == n - 1);
        b.stall = rq[c];
        if (we) begin
          b.data = wd[idx];
          ref_mem[b.addr] = wd[idx];
        end else begin
          b.data = ref_mem[b.addr];
        end
        bq.push_back(b);
        sched.push_back(idx);
        if (rq[c]) exp_stalls++;
        beats++;
        if (beats < n) begin
          run++;
          if (run >= CHUNK && rq[c]) yield_next = 1'b1;
        end
      end
    end

    for (int c = 1; c <= sched.size(); c++) begin
      @(posedge clk); #1;
      if (stop_after > 0 && c > stop_after) begin
        reset     = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        host_req  = 1'b1;
        #1;
        chk("rst_host_beat", host_beat, 0);
        chk("rst_host_done", host_done, 0);
        chk("rst_host_gnt", host_gnt, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_cpu_stall", cpu_stall, 0);
`ifdef DMEM_ARB_STATS_EN
        chk("rst_stall_cnt", cpu_stall_cnt, 0);
`endif
        bq.delete();
        repeat (2) @(posedge clk);
        #1;
        host_req = 1'b0;
        cpu_req  = 1'b0;
        cpu_we   = 1'b0;
        reset    = 1'b1;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          chk("post_rst_idle_beat", host_beat, 0);
          chk("post_rst_idle_done", host_done, 0);
        end
        return;
      end
      cpu_req    = rq[c];
      cpu_we     = 1'b0;
      cpu_addr   = 8'($urandom);
      host_req   = 1'($urandom_range(1));
      host_we    = 1'($urandom_range(1));
      host_addr  = 8'($urandom);
      host_len   = 8'($urandom);
      host_wdata = (sched[c-1] >= 0) ? wd[sched[c-1]] : 8'($urandom);
      @(negedge clk);
    end

    @(posedge clk); #1;
    host_req = 1'b0;
    cpu_req  = 1'b0;
    @(negedge clk); #1;
    chk("beat_queue_drained", bq.size(), 0);
    bq.delete();
`ifdef DMEM_ARB_STATS_EN
    chk("stall_cnt_delta", 32'(cpu_stall_cnt - cnt0), exp_stalls);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h12; cpu_wdata = 8'h34;
    host_req = 1'b1; host_we = 1'b0; host_addr = '0; host_len = '0; host_wdata = '0;
    #12;
    chk("reset_mem_we", mem_we, 0);
    chk("reset_cpu_stall", cpu_stall, 0);
    chk("reset_host_beat", host_beat, 0);
    chk("reset_host_done", host_done, 0);
    cpu_req = 1'b0;
    #1;
    chk("reset_host_gnt", host_gnt, 0);
`ifdef DMEM_ARB_STATS_EN
    chk("reset_stall_cnt", cpu_stall_cnt, 0);
`endif
    @(posedge clk); #1;
    host_req = 1'b0; cpu_we = 1'b0;
    reset = 1'b1;

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    cpu_phase(256, 1'b1);
    cpu_phase(40, 1'b0);

    burst(8'hFE, 8'd3, 1'b1, 0, 0, 1'b1, 0);
    burst(8'hFE, 8'd3, 1'b0, 0, 0, 1'b0, 0);
    burst(8'h40, 8'd9, 1'b0, 0, 1, 1'b0, 0);
    burst(8'h80, 8'd2, 1'b0, 1, 0, 1'b0, 0);
    burst(8'h10, 8'd0, 1'b1, 0, 1, 1'b0, 0);
    burst(8'h10, 8'd0, 1'b0, 2, 2, 1'b0, 0);
    burst(8'h20, 8'd5, 1'b0, 0, 0, 1'b0, 2);
    cpu_phase(10, 1'b0);

    for (int r = 0; r < 14; r++) begin
      burst(8'($urandom), 8'($urandom_range(20)), 1'($urandom_range(1)), 2, 2, 1'b0, 0);
      cpu_phase(8, 1'b0);
    end
    burst(8'hF0, 8'd31, 1'b0, 2, 2, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
